// File: rtl/gtp_pkg.sv
// Shared constants and types for the GTP link test-pattern generator and checker.
// Word encodings, PRBS-7 seed and the generator state enum.
package gtp_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D21_2 = 8'h55;

    localparam logic [15:0] COMMA_WORD = {D16_2, K28_5};
    localparam logic [15:0] SOF_WORD   = {D21_2, K27_7};
    localparam logic [1:0]  K_LOW      = 2'b01;
    localparam logic [1:0]  K_NONE     = 2'b00;
    localparam logic [6:0]  PRBS7_SEED = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SOF,
        DATA,
        KEEP
    } state_t;

endpackage

// File: rtl/gtp_prbs_gen_prbs7_par16.sv
// PRBS-7 (x^7+x^6+1) advanced 16 steps per call; bit 0 is the first new bit.
// Shared with the receive-side checker so both ends agree on bit order.
module prbs7_par16 (
    input  logic [6:0]  state,
    output logic [15:0] word,
    output logic [6:0]  next_state
);

    logic [6:0] s;

    always_comb begin
        s    = state;
        word = '0;
        for (int i = 0; i < 16; i++) begin
            word[i] = s[6] ^ s[5];
            s       = {s[5:0], s[6] ^ s[5]};
        end
        next_state = s;
    end

endmodule

// File: rtl/gtp_prbs_gen.sv
// GTP lane pattern generator: commas, SOF, then PRBS-7 payload with keep-alives.
// Outputs are registered from the next-state decision, giving one cycle latency.
module gtp_prbs_gen
    import gtp_pkg::*;
#(
    parameter int         ALIGN_LEN = 16,
    parameter int         FRAME_LEN = 1024,
    parameter logic [6:0] SEED      = PRBS7_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_ready,
    input  logic        enable,
    input  logic        inject_err,
    output logic [15:0] txdata,
    output logic [1:0]  txcharisk,
    output logic        running,
    output logic        err_injected,
    output logic [31:0] words_sent
);

    localparam int AW = $clog2(ALIGN_LEN + 1);
    localparam int FW = $clog2(FRAME_LEN + 1);

    state_t        state;
    state_t        nxt;
    logic [AW-1:0] align_cnt;
    logic [FW-1:0] frame_cnt;
    logic [6:0]    lfsr;
    logic [6:0]    lfsr_nxt;
    logic [15:0]   prbs_word;
    logic          pend;
    logic          consume;
    logic          go;
    logic          enter_align;
    logic          enter_idle;

    prbs7_par16 u_prbs (
        .state      (lfsr),
        .word       (prbs_word),
        .next_state (lfsr_nxt)
    );

    assign go          = enable & tx_ready;
    assign consume     = pend & (nxt == DATA);
    assign enter_align = (nxt == ALIGN) & (state != ALIGN);
    assign enter_idle  = (nxt == IDLE) & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (!go) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    nxt = ALIGN;
                ALIGN:   if (align_cnt == AW'(ALIGN_LEN)) nxt = SOF;
                SOF:     nxt = DATA;
                DATA:    if (frame_cnt == FW'(FRAME_LEN)) nxt = KEEP;
                KEEP:    nxt = DATA;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txdata       <= COMMA_WORD;
            txcharisk    <= K_LOW;
            running      <= 1'b0;
            err_injected <= 1'b0;
            words_sent   <= '0;
            lfsr         <= SEED;
            pend         <= 1'b0;
            align_cnt    <= '0;
            frame_cnt    <= '0;
        end else begin
            err_injected <= consume;
            running      <= (nxt == SOF) | (nxt == DATA) | (nxt == KEEP);
            // A new request in the consuming cycle re-arms for the next word
            pend         <= enter_idle ? 1'b0 : (inject_err | (pend & ~consume));

            if (enter_align)         align_cnt <= AW'(1);
            else if (state == ALIGN) align_cnt <= align_cnt + 1'b1;

            unique case (nxt)
                DATA: begin
                    txdata     <= prbs_word ^ {15'd0, consume};
                    txcharisk  <= K_NONE;
                    lfsr       <= lfsr_nxt;
                    words_sent <= words_sent + 32'd1;
                    frame_cnt  <= frame_cnt + 1'b1;
                end
                SOF: begin
                    txdata    <= SOF_WORD;
                    txcharisk <= K_LOW;
                end
                KEEP: begin
                    txdata    <= COMMA_WORD;
                    txcharisk <= K_LOW;
                    frame_cnt <= '0;
                end
                ALIGN: begin
                    txdata    <= COMMA_WORD;
                    txcharisk <= K_LOW;
                    if (enter_align) begin
                        lfsr       <= SEED;
                        words_sent <= '0;
                        frame_cnt  <= '0;
                    end
                end
                default: begin
                    txdata    <= COMMA_WORD;
                    txcharisk <= K_LOW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gtp_prbs_gen.sv
// Bench for gtp_prbs_gen: startup, framing, error injection, aborts, reset.
// Expected words come from a bit-level PRBS-7 recurrence and stream arithmetic.
module tb_gtp_prbs_gen;

    localparam int ALEN = 16;
    localparam int FLEN = 4;
    localparam int NW   = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_ready = 1'b0;
    logic        enable = 1'b0;
    logic        inject_err = 1'b0;
    logic [15:0] txdata;
    logic [1:0]  txcharisk;
    logic        running;
    logic        err_injected;
    logic [31:0] words_sent;

    int n_checks = 0;
    int n_fail = 0;

    logic bits [0:16*NW+6];

    always #5 clk = ~clk;

    gtp_prbs_gen #(
        .ALIGN_LEN (ALEN),
        .FRAME_LEN (FLEN),
        .SEED      (7'h7F)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_ready     (tx_ready),
        .enable       (enable),
        .inject_err   (inject_err),
        .txdata       (txdata),
        .txcharisk    (txcharisk),
        .running      (running),
        .err_injected (err_injected),
        .words_sent   (words_sent)
    );

    // bits[j] holds PRBS bit j-7; the seed supplies bits -7..-1
    task automatic build_model();
        logic [6:0] seed;
        seed = 7'h7F;
        for (int k = 0; k < 7; k++) bits[6-k] = seed[k];
        for (int j = 7; j < 16*NW+7; j++) bits[j] = bits[j-7] ^ bits[j-6];
    endtask

    function automatic logic [15:0] model_word(input int k);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = bits[7 + 16*k + i];
        return w;
    endfunction

    // Payload stream position p: FLEN data words then one keep-alive comma
    function automatic logic [17:0] stream_exp(input int p);
        int r;
        r = p % (FLEN + 1);
        if (r == FLEN) return {16'h50BC, 2'b01};
        return {model_word((p / (FLEN + 1)) * FLEN + r), 2'b00};
    endfunction

    function automatic int data_upto(input int p);
        return ((p + 1) / (FLEN + 1)) * FLEN + ((p + 1) % (FLEN + 1));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
        tx_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (txdata !== 16'h50BC) begin
            n_fail++;
            $display("FAIL reset_txdata got %h want 50bc", txdata);
        end
        n_checks++;
        if (txcharisk !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_charisk got %b want 01", txcharisk);
        end
        n_checks++;
        if ({running, err_injected} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00", {running, err_injected});
        end
        n_checks++;
        if (words_sent !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_words got %0d want 0", words_sent);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_startup();
        n_checks++;
        if ({txdata, txcharisk, running} !== {16'h50BC, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL startup_idle got %h want %h",
                     {txdata, txcharisk, running}, {16'h50BC, 2'b01, 1'b0});
        end
        enable = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < ALEN; i++) begin
            step();
            n_checks++;
            if ({txdata, txcharisk, running} !== {16'h50BC, 2'b01, 1'b0}) begin
                n_fail++;
                $display("FAIL startup_align%0d got %h want %h", i,
                         {txdata, txcharisk, running}, {16'h50BC, 2'b01, 1'b0});
            end
        end
        step();
        n_checks++;
        if ({txdata, txcharisk, running} !== {16'h55FB, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL startup_sof got %h want %h",
                     {txdata, txcharisk, running}, {16'h55FB, 2'b01, 1'b1});
        end
        step();
        n_checks++;
        if ({txdata, txcharisk, running, err_injected} !== {16'h3040, 2'b00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL startup_data0 got %h want %h",
                     {txdata, txcharisk, running, err_injected},
                     {16'h3040, 2'b00, 1'b1, 1'b0});
        end
        n_checks++;
        if (words_sent !== 32'd1) begin
            n_fail++;
            $display("FAIL startup_words got %0d want 1", words_sent);
        end
    endtask

    // Continues the run begun by test_startup (payload position 0 is out)
    task automatic test_frame();
        int n;
        n = $urandom_range(12, 40);
        for (int p = 1; p <= n; p++) begin
            step();
            n_checks++;
            if ({txdata, txcharisk, running} !== {stream_exp(p), 1'b1}) begin
                n_fail++;
                $display("FAIL frame_pos%0d got %h want %h", p,
                         {txdata, txcharisk, running}, {stream_exp(p), 1'b1});
            end
            n_checks++;
            if (words_sent !== 32'(data_upto(p))) begin
                n_fail++;
                $display("FAIL frame_words%0d got %0d want %0d", p,
                         words_sent, data_upto(p));
            end
        end
    endtask

    task automatic test_inject();
        int a, b, c;
        restart();
        a = $urandom_range(0, 4);
        b = a + 2 + $urandom_range(0, 4);
        c = b + 2 + $urandom_range(0, 4);
        for (int i = 0; i < ALEN; i++) begin
            inject_err = (i == a) || (i == b) || (i == c);
            step();
        end
        inject_err = 1'b0;
        n_checks++;
        if ({txdata, running} !== {16'h55FB, 1'b1}) begin
            n_fail++;
            $display("FAIL inject_sof got %h want %h", {txdata, running}, {16'h55FB, 1'b1});
        end
        step();
        n_checks++;
        if ({txdata, txcharisk, err_injected} !== {16'h3041, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL inject_first got %h want %h",
                     {txdata, txcharisk, err_injected}, {16'h3041, 2'b00, 1'b1});
        end
        step();
        n_checks++;
        if ({txdata, txcharisk, err_injected} !== {model_word(1), 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL inject_second got %h want %h",
                     {txdata, txcharisk, err_injected}, {model_word(1), 2'b00, 1'b0});
        end
    endtask

    // Continues from test_inject (payload position 1 is out)
    task automatic test_abort();
        int pos;
        pos = 1 + $urandom_range(1, 6);
        for (int i = 2; i <= pos; i++) step();
        if (pos % (FLEN + 1) == FLEN) begin
            step();
            pos++;
        end
        tx_ready = 1'b0;
        step();
        n_checks++;
        if ({txdata, txcharisk, running} !== {16'h50BC, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_comma got %h want %h",
                     {txdata, txcharisk, running}, {16'h50BC, 2'b01, 1'b0});
        end
        n_checks++;
        if (words_sent !== 32'(data_upto(pos))) begin
            n_fail++;
            $display("FAIL abort_hold got %0d want %0d", words_sent, data_upto(pos));
        end
        tx_ready = 1'b1;
        step();
        n_checks++;
        if ({words_sent, running} !== {32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_realign got %h want %h", {words_sent, running}, {32'd0, 1'b0});
        end
        for (int i = 1; i < ALEN; i++) step();
        step();
        n_checks++;
        if ({txdata, running} !== {16'h55FB, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_sof got %h want %h", {txdata, running}, {16'h55FB, 1'b1});
        end
        step();
        n_checks++;
        if ({txdata, txcharisk} !== {16'h3040, 2'b00}) begin
            n_fail++;
            $display("FAIL abort_data0 got %h want %h", {txdata, txcharisk}, {16'h3040, 2'b00});
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({txdata, txcharisk, running, err_injected} !== {16'h50BC, 2'b01, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_out got %h want %h",
                     {txdata, txcharisk, running, err_injected},
                     {16'h50BC, 2'b01, 1'b0, 1'b0});
        end
        n_checks++;
        if (words_sent !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_words got %0d want 0", words_sent);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_toggle();
        for (int i = 0; i <= ALEN + 3; i++) step();
        enable = 1'b0;
        step();
        n_checks++;
        if ({txdata, txcharisk, running} !== {16'h50BC, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL toggle_idle got %h want %h",
                     {txdata, txcharisk, running}, {16'h50BC, 2'b01, 1'b0});
        end
        n_checks++;
        if (words_sent !== 32'd3) begin
            n_fail++;
            $display("FAIL toggle_hold got %0d want 3", words_sent);
        end
        enable = 1'b1;
        step();
        n_checks++;
        if ({txdata, running, words_sent} !== {16'h50BC, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL toggle_align got %h want %h",
                     {txdata, running, words_sent}, {16'h50BC, 1'b0, 32'd0});
        end
        for (int i = 1; i < ALEN; i++) step();
        step();
        step();
        n_checks++;
        if ({txdata, words_sent} !== {16'h3040, 32'd1}) begin
            n_fail++;
            $display("FAIL toggle_data0 got %h want %h", {txdata, words_sent}, {16'h3040, 32'd1});
        end
    endtask

    task automatic test_random_inject();
        logic        pend;
        logic        inj;
        logic [17:0] exp;
        logic        exp_run;
        logic        exp_err;
        int          q;
        restart();
        pend = 1'b0;
        q = 0;
        for (int c = 0; c < 90; c++) begin
            inj = ($urandom_range(0, 5) == 0);
            inject_err = inj;
            step();
            q++;
            exp_err = 1'b0;
            if (q < ALEN) begin
                exp = {16'h50BC, 2'b01};
                exp_run = 1'b0;
            end else if (q == ALEN) begin
                exp = {16'h55FB, 2'b01};
                exp_run = 1'b1;
            end else begin
                exp = stream_exp(q - ALEN - 1);
                exp_run = 1'b1;
                if (exp[1:0] == 2'b00 && pend) begin
                    exp[2] = ~exp[2];
                    exp_err = 1'b1;
                    pend = 1'b0;
                end
            end
            pend = pend | inj;
            n_checks++;
            if ({txdata, txcharisk, running, err_injected} !== {exp, exp_run, exp_err}) begin
                n_fail++;
                $display("FAIL rand_q%0d got %h want %h", q,
                         {txdata, txcharisk, running, err_injected},
                         {exp, exp_run, exp_err});
            end
        end
        inject_err = 1'b0;
    endtask

    initial begin
        build_model();
        test_reset();
        test_startup();
        test_frame();
        test_inject();
        test_abort();
        test_async_reset();
        test_toggle();
        test_random_inject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
